pipe_controller: RTL

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipe_controller.sv
`timescale 1ns/1ps
// pipe_controller
// Moves the two scrolling pipes of the game once per video frame. It picks new
// gap heights from an LFSR when a pipe wraps, counts the pipes the bird has
// passed, and runs the IDLE / RUN / DEAD game state machine.
//
// Ports
//   Clk        system clock; all state changes on its rising edge
//   Reset      asynchronous, active-high; forces the IDLE start-of-game state
//   frame_clk  vertical-sync level; each rising edge is one frame tick
//   start      level, start/restart request
//   hit        level, collision flag
//   PipeX0/1   pipe left-edge X in pixels
//   PipeGap0/1 gap-top Y; the gap spans [gap, gap+119]
//   Score      pipes passed; saturates at 255
//   Running    high only while the game is in RUN
module pipe_controller #(
  parameter int SPEED   = 2,
  parameter int SPACING = 320,
  parameter int GAP_MIN = 40,
  parameter int BIRD_X  = 160
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       hit,
  output logic [9:0] PipeX0,
  output logic [9:0] PipeX1,
  output logic [9:0] PipeGap0,
  output logic [9:0] PipeGap1,
  output logic [7:0] Score,
  output logic       Running
);

  // A wrapped pipe reappears at 2*SPACING-SPEED, which is exactly where it
  // would have been had it kept moving from 2*SPACING. That keeps the two
  // pipes SPACING apart forever.
  localparam logic [9:0] RELOAD_X  = 10'(2 * SPACING - SPEED);
  localparam logic [9:0] SPEED_V   = 10'(SPEED);
  localparam logic [9:0] BIRD_V    = 10'(BIRD_X);
  localparam logic [9:0] GAP_MIN_V = 10'(GAP_MIN);
  localparam logic [9:0] INIT_GAP  = 10'd200;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t     state_reg, state_next;
  logic       sync1_reg, sync2_reg, prev_reg;
  logic       tick;
  logic [7:0] lfsr_reg;
  logic [7:0] score_reg, score_next;
  logic [8:0] score_sum;
  logic       move, load_init;
  logic [1:0] pass;

  // frame_clk is asynchronous to Clk: two synchronizer flops, then one more
  // flop for the rising-edge detect. The tick is therefore high in the
  // cycle before the third Clk edge after the rise, and the pipes move on
  // that third edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= frame_clk;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign tick = sync2_reg & ~prev_reg;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (maximal length). It free-runs in
  // every state, so the gap picked depends on how long the player waited.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // A hit takes priority over both start and a tick in the same cycle.
  always_comb begin
    state_next = state_reg;
    move       = 1'b0;
    load_init  = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (hit)       state_next = DEAD;
        else if (tick) move = 1'b1;
      end
      DEAD: begin
        if (start) begin
          state_next = IDLE;
          load_init  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
    localparam logic [9:0] INIT_X = 10'((gi + 2) * SPACING);

    logic [9:0] x_reg, x_next, gap_reg, gap_next;
    logic       passed;

    always_comb begin
      x_next   = x_reg;
      gap_next = gap_reg;
      passed   = 1'b0;
      if (load_init) begin
        x_next   = INIT_X;
        gap_next = INIT_GAP;
      end else if (move) begin
        if (x_reg < SPEED_V) begin
          x_next   = RELOAD_X;
          gap_next = GAP_MIN_V + {2'b00, lfsr_reg};
        end else begin
          x_next = x_reg - SPEED_V;
          passed = (x_reg > BIRD_V) && (x_next <= BIRD_V);
        end
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        x_reg   <= INIT_X;
        gap_reg <= INIT_GAP;
      end else begin
        x_reg   <= x_next;
        gap_reg <= gap_next;
      end
    end

    assign pass[gi] = passed;
  end

  // Both pipes could in principle pass on one tick, so add both bits and
  // clamp at 255.
  always_comb begin
    score_sum  = {1'b0, score_reg} + {8'd0, pass[0]} + {8'd0, pass[1]};
    score_next = score_reg;
    if (load_init)  score_next = 8'd0;
    else if (move)  score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) score_reg <= 8'd0;
    else       score_reg <= score_next;
  end

  assign PipeX0   = g_pipe[0].x_reg;
  assign PipeX1   = g_pipe[1].x_reg;
  assign PipeGap0 = g_pipe[0].gap_reg;
  assign PipeGap1 = g_pipe[1].gap_reg;
  assign Score    = score_reg;
  assign Running  = (state_reg == RUN);

endmodule
